picorvino_boot_loader: RTL and testbench
========================================

Name: picorvino_boot_loader

Overview:
- Synthesizable firmware preloader for picorvino-class SoCs; replaces simulation-only memory initialisation.
- After reset it accepts a segmented firmware image on a valid/ready word stream.
- It writes each word into a NUM_BANKS word-interleaved instruction/data memory.
- It holds the core in reset until the full image is loaded, then releases it after a programmable hold time.

Parameters:
- DATA_W, 32, stream and memory word width; also header word width.
- MEM_WORDS, 4096, words per bank.
- NUM_BANKS, 1, number of interleaved banks; power of 2, 1..8.
- RST_HOLD, 16, cycles core_rstn stays low after the end marker is accepted; must be ≥1.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- ld_valid  in  1  stream word valid
- ld_ready  out  1  stream word accepted when ld_valid&ld_ready
- ld_data  in  DATA_W  stream word
- mem_we  out  1  memory write strobe, one cycle per word
- mem_bank  out  max(1,$clog2(NUM_BANKS))  target bank
- mem_addr  out  $clog2(MEM_WORDS)  word address within bank
- mem_wdata  out  DATA_W  write data
- core_rstn  out  1  active-low reset to the core
- boot_done  out  1  image loaded, core released
- boot_err  out  1  sticky load error
- words_loaded  out  32  count of data words written

Behaviour:
- Interface fixed: one clock (clk); reset rstn is asynchronous, active-low.
- Reset values:
  - State = HDR_ADDR.
  - ld_ready=0, mem_we=0, mem_bank=0, mem_addr=0, mem_wdata=0.
  - core_rstn=0, boot_done=0, boot_err=0, words_loaded=0.
- ld_ready is registered:
  - 1 in HDR_ADDR, HDR_LEN, DATA (and CSUM when enabled).
  - 0 in HOLD, RUN, ERR.
  - Rises the first cycle after reset deassertion.
- Stream format: repeated segments of {start word index W, length N, N data words}. A segment with N=0 is the end marker; its W is ignored.
- Global word index w maps as: mem_bank = w mod NUM_BANKS, mem_addr = w / NUM_BANKS. Total capacity is C = MEM_WORDS*NUM_BANKS.
- States:
  - HDR_ADDR: on accept, latch W → HDR_LEN.
  - HDR_LEN: on accept, latch N.
    - N=0 → HOLD (or CSUM when enabled).
    - W+N > C, computed in DATA_W+1 bits with no wrap → ERR.
    - Otherwise → DATA.
  - DATA: each accepted word is written to the current w. Then w increments, the remaining count decrements, and words_loaded increments (saturating at 2^32-1). When the last word is accepted → HDR_ADDR.
  - HOLD: counter runs RST_HOLD cycles, then → RUN.
  - RUN: core_rstn=1 and boot_done=1, both asserted in the same cycle. Terminal state until rstn.
  - ERR: boot_err=1, core_rstn=0, boot_done=0. Terminal state until rstn.
- Write latency: a word accepted in cycle t appears on mem_* with mem_we=1 in cycle t+1. mem_we=0 in every other cycle. Back-to-back accepts produce back-to-back writes.
- ld_valid low mid-segment: pause with no writes; the state is held. No timeout.
- Segments may overlap or arrive in any order; a later write wins.
- Reset asserted mid-load: everything returns to reset values immediately. The memory is not cleared. Reload restarts from HDR_ADDR.
- Stream words presented after RUN/ERR are never accepted.

Optional Feature:
- Macro: PICORVINO_BOOT_CHECKSUM_EN.
- When defined:
  - Accepting the end marker → CSUM state.
  - One more word is accepted in CSUM. It is compared with the running sum, mod 2^DATA_W, of all data words written.
  - Match → HOLD; mismatch → ERR.
  - The running sum resets to 0 on rstn.
- When undefined: no CSUM state, no summing logic; the end marker goes directly to HOLD.

Test Plan:
- NUM_BANKS=1, stream {0,4,A0..A3},{x,0} with ld_valid held high:
  - Writes go to addr 0..3 on consecutive cycles, each one cycle after accept.
  - core_rstn and boot_done rise exactly 16 cycles after the end marker accept.
  - words_loaded=4.
- NUM_BANKS=4, stream {5,3,D0,D1,D2},{x,0} → (bank,addr) = (1,1),(2,1),(3,1).
- MEM_WORDS=16, NUM_BANKS=1, header {14,3} → ERR after HDR_LEN accept: boot_err=1, ld_ready=0, core_rstn stays 0, no mem_we.
- Random ld_valid gaps over {0,8,...},{100,2,...},{x,0}:
  - Exactly 10 writes, contents match the model.
  - No write occurs in any cycle without a prior accept.
- Assert rstn low after 2 of 4 data words, then reload the full image:
  - Outputs are at reset values during reset.
  - Second load completes to RUN; words_loaded=4, not 6.
- With PICORVINO_BOOT_CHECKSUM_EN, image {0,2,1,2},{x,0}:
  - Checksum 3 → RUN.
  - Checksum 4 → ERR, boot_err=1.

Source files
------------

// File: rtl/picorvino_boot_loader.sv
// Firmware preloader: streams a segmented image into word-interleaved memory, then releases the core.
// Optional trailing checksum word after the end marker is enabled by defining PICORVINO_BOOT_CHECKSUM_EN.
module picorvino_boot_loader #(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 4096,
  parameter int NUM_BANKS = 1,
  parameter int RST_HOLD  = 16
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       ld_valid,
  output logic                                       ld_ready,
  input  logic [DATA_W-1:0]                          ld_data,
  output logic                                       mem_we,
  output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] mem_bank,
  output logic [$clog2(MEM_WORDS)-1:0]               mem_addr,
  output logic [DATA_W-1:0]                          mem_wdata,
  output logic                                       core_rstn,
  output logic                                       boot_done,
  output logic                                       boot_err,
  output logic [31:0]                                words_loaded
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int LB = $clog2(NUM_BANKS);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [DATA_W:0]   CAP       = (DATA_W+1)'(MEM_WORDS * NUM_BANKS);
  localparam logic [DATA_W-1:0] BANK_MASK = DATA_W'(NUM_BANKS - 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(RST_HOLD - 1);

`ifdef PICORVINO_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {HDR_ADDR, HDR_LEN, DATA, CSUM, HOLD, RUN, ERR} state_t;
  logic [DATA_W-1:0] sum;
`else
  typedef enum logic [2:0] {HDR_ADDR, HDR_LEN, DATA, HOLD, RUN, ERR} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] w_idx;
  logic [DATA_W-1:0] remain;
  logic [HW-1:0]     hold_cnt;
  logic              acc;
  logic [DATA_W:0]   seg_end;

  assign acc     = ld_valid & ld_ready;
  // One extra bit so a header near the top of the word range cannot wrap past the capacity check.
  assign seg_end = {1'b0, w_idx} + {1'b0, ld_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= HDR_ADDR;
      ld_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_bank     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_rstn    <= 1'b0;
      boot_done    <= 1'b0;
      boot_err     <= 1'b0;
      words_loaded <= '0;
      w_idx        <= '0;
      remain       <= '0;
      hold_cnt     <= '0;
`ifdef PICORVINO_BOOT_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR_ADDR: begin
          ld_ready <= 1'b1;
          if (acc) begin
            w_idx <= ld_data;
            state <= HDR_LEN;
          end
        end
        HDR_LEN: if (acc) begin
          if (ld_data == '0) begin
`ifdef PICORVINO_BOOT_CHECKSUM_EN
            state    <= CSUM;
`else
            state    <= HOLD;
            ld_ready <= 1'b0;
            hold_cnt <= '0;
`endif
          end else if (seg_end > CAP) begin
            state    <= ERR;
            ld_ready <= 1'b0;
            boot_err <= 1'b1;
          end else begin
            remain <= ld_data;
            state  <= DATA;
          end
        end
        DATA: if (acc) begin
          mem_we    <= 1'b1;
          mem_bank  <= BW'(w_idx & BANK_MASK);
          mem_addr  <= AW'(w_idx >> LB);
          mem_wdata <= ld_data;
          w_idx     <= w_idx + 1'b1;
          remain    <= remain - 1'b1;
          if (words_loaded != 32'hFFFF_FFFF) words_loaded <= words_loaded + 32'd1;
`ifdef PICORVINO_BOOT_CHECKSUM_EN
          sum       <= sum + ld_data;
`endif
          if (remain == DATA_W'(1)) state <= HDR_ADDR;
        end
`ifdef PICORVINO_BOOT_CHECKSUM_EN
        CSUM: if (acc) begin
          ld_ready <= 1'b0;
          if (ld_data == sum) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end else begin
            state    <= ERR;
            boot_err <= 1'b1;
          end
        end
`endif
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            core_rstn <= 1'b1;
            boot_done <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: ld_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_picorvino_boot_loader.sv
// Directed bench: three loader instances share one stream and are checked against hand-computed values.
module tb_picorvino_boot_loader;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ld_valid;
  logic [31:0] ld_data;

  logic        rdy_a, we_a, crst_a, done_a, err_a;
  logic [0:0]  bank_a;
  logic [11:0] addr_a;
  logic [31:0] wdata_a, wl_a;

  logic        rdy_b, we_b, crst_b, done_b, err_b;
  logic [1:0]  bank_b;
  logic [11:0] addr_b;
  logic [31:0] wdata_b, wl_b;

  logic        rdy_c, we_c, crst_c, done_c, err_c;
  logic [0:0]  bank_c;
  logic [3:0]  addr_c;
  logic [31:0] wdata_c, wl_c;

  always #5 clk = ~clk;

  picorvino_boot_loader u_a (
    .clk(clk), .rstn(rstn), .ld_valid(ld_valid), .ld_ready(rdy_a), .ld_data(ld_data),
    .mem_we(we_a), .mem_bank(bank_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
    .core_rstn(crst_a), .boot_done(done_a), .boot_err(err_a), .words_loaded(wl_a));

  picorvino_boot_loader #(.NUM_BANKS(4)) u_b (
    .clk(clk), .rstn(rstn), .ld_valid(ld_valid), .ld_ready(rdy_b), .ld_data(ld_data),
    .mem_we(we_b), .mem_bank(bank_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .core_rstn(crst_b), .boot_done(done_b), .boot_err(err_b), .words_loaded(wl_b));

  picorvino_boot_loader #(.MEM_WORDS(16)) u_c (
    .clk(clk), .rstn(rstn), .ld_valid(ld_valid), .ld_ready(rdy_c), .ld_data(ld_data),
    .mem_we(we_c), .mem_bank(bank_c), .mem_addr(addr_c), .mem_wdata(wdata_c),
    .core_rstn(crst_c), .boot_done(done_c), .boot_err(err_c), .words_loaded(wl_c));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int          cyc = 0;
  int          nwr_a = 0;
  int          nwr_c = 0;
  logic        acc_q = 1'b0;
  logic [31:0] cap [int];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    acc_q <= ld_valid & rdy_a;
  end

  // Every write must follow an accept on the previous edge.
  always @(negedge clk) begin
    if (we_a) begin
      check("we_after_acc", {31'd0, acc_q}, 32'd1);
      nwr_a++;
      cap[int'(addr_a)] = wdata_a;
    end
    if (we_c) nwr_c++;
  end

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    while (!rdy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("send_rdy", {31'd0, rdy_a}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    ld_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic end_image(input logic [31:0] csum);
    send(32'hDEAD_BEEF);
    send(32'd0);
`ifdef PICORVINO_BOOT_CHECKSUM_EN
    send(csum);
`endif
    ld_valid = 1'b0;
  endtask

  task automatic do_reset();
    ld_valid = 1'b0;
    rstn     = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_run(output int k);
    k = 0;
    while (!crst_a && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int          k, base, c0, base_c;
    logic [31:0] s, d;
    logic [31:0] expm [int];

    rstn     = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, rdy_a}, 0);
    check("rst_we", {31'd0, we_a}, 0);
    check("rst_addr", {20'd0, addr_a}, 0);
    check("rst_wdata", wdata_a, 0);
    check("rst_core_rstn", {31'd0, crst_a}, 0);
    check("rst_done", {31'd0, done_a}, 0);
    check("rst_err", {31'd0, err_a}, 0);
    check("rst_words", wl_a, 0);
    rstn = 1'b1;
    #1 check("ready_still_low", {31'd0, rdy_a}, 0);
    @(negedge clk);
    check("ready_rise", {31'd0, rdy_a}, 1);

    // Basic single-bank load, valid held high throughout.
    base = nwr_a;
    send(32'd0);
    check("hdr_no_we", {31'd0, we_a}, 0);
    send(32'd4);
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      send(32'h10 * (i + 1));
      check("t1_we", {31'd0, we_a}, 1);
      check("t1_addr", {20'd0, addr_a}, i);
      check("t1_bank", {31'd0, bank_a}, 0);
      check("t1_wdata", wdata_a, 32'h10 * (i + 1));
    end
    check("t1_b2b_cycles", cyc - c0, 4);
    end_image(32'hA0);
    check("hold_ready_low", {31'd0, rdy_a}, 0);
    wait_run(k);
    check("hold_cycles", k, 16);
    check("t1_done", {31'd0, done_a}, 1);
    check("t1_err", {31'd0, err_a}, 0);
    check("t1_words", wl_a, 4);
    ld_valid = 1'b1;
    ld_data  = 32'h1234;
    repeat (3) @(negedge clk);
    check("run_ready", {31'd0, rdy_a}, 0);
    check("run_words", wl_a, 4);
    check("t1_nwrites", nwr_a - base, 4);
    ld_valid = 1'b0;

    // Four-bank interleaving.
    do_reset();
    send(32'd5);
    send(32'd3);
    for (int i = 0; i < 3; i++) begin
      send(32'hD0 + i);
      check("t2_we", {31'd0, we_b}, 1);
      check("t2_bank", {30'd0, bank_b}, i + 1);
      check("t2_addr", {20'd0, addr_b}, 1);
      check("t2_wdata", wdata_b, 32'hD0 + i);
    end
    end_image(32'h273);

    // Oversized segment on a 16-word memory.
    do_reset();
    base_c = nwr_c;
    send(32'd14);
    send(32'd3);
    check("t3_err", {31'd0, err_c}, 1);
    check("t3_ready", {31'd0, rdy_c}, 0);
    check("t3_core_rstn", {31'd0, crst_c}, 0);
    check("t3_done", {31'd0, done_c}, 0);
    for (int i = 0; i < 3; i++) send(32'hE0 + i);
    end_image(32'h2A3);
    repeat (20) @(negedge clk);
    check("t3_core_rstn_late", {31'd0, crst_c}, 0);
    check("t3_err_sticky", {31'd0, err_c}, 1);
    check("t3_no_writes", nwr_c - base_c, 0);

    // Random valid gaps over two segments.
    do_reset();
    base = nwr_a;
    s    = '0;
    idle($urandom_range(0, 3)); send(32'd0);
    idle($urandom_range(0, 3)); send(32'd8);
    for (int i = 0; i < 8; i++) begin
      d = 32'h5A00_0000 | i;
      expm[i] = d;
      s += d;
      idle($urandom_range(0, 3)); send(d);
    end
    idle($urandom_range(0, 3)); send(32'd100);
    idle($urandom_range(0, 3)); send(32'd2);
    for (int i = 0; i < 2; i++) begin
      d = 32'hB000_0100 | i;
      expm[100 + i] = d;
      s += d;
      idle($urandom_range(0, 3)); send(d);
    end
    end_image(s);
    wait_run(k);
    check("t4_done", {31'd0, done_a}, 1);
    check("t4_nwrites", nwr_a - base, 10);
    check("t4_words", wl_a, 10);
    foreach (expm[a]) check("t4_mem", cap[a], expm[a]);

    // Reset in the middle of a segment, then a full reload.
    do_reset();
    send(32'd0);
    send(32'd4);
    send(32'h10);
    send(32'h20);
    rstn     = 1'b0;
    ld_valid = 1'b0;
    #1;
    check("t5_ready", {31'd0, rdy_a}, 0);
    check("t5_we", {31'd0, we_a}, 0);
    check("t5_addr", {20'd0, addr_a}, 0);
    check("t5_wdata", wdata_a, 0);
    check("t5_words", wl_a, 0);
    check("t5_core_rstn", {31'd0, crst_a}, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(32'd0);
    send(32'd4);
    for (int i = 0; i < 4; i++) send(32'h10 * (i + 1));
    end_image(32'hA0);
    wait_run(k);
    check("t5_done", {31'd0, done_a}, 1);
    check("t5_reload_words", wl_a, 4);

`ifdef PICORVINO_BOOT_CHECKSUM_EN
    do_reset();
    send(32'd0); send(32'd2); send(32'd1); send(32'd2);
    send(32'hFFFF); send(32'd0); send(32'd3);
    ld_valid = 1'b0;
    wait_run(k);
    check("cs_good_done", {31'd0, done_a}, 1);
    check("cs_good_err", {31'd0, err_a}, 0);
    do_reset();
    send(32'd0); send(32'd2); send(32'd1); send(32'd2);
    send(32'hFFFF); send(32'd0); send(32'd4);
    ld_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("cs_bad_err", {31'd0, err_a}, 1);
    check("cs_bad_done", {31'd0, done_a}, 0);
    check("cs_bad_core_rstn", {31'd0, crst_a}, 0);
    check("cs_bad_ready", {31'd0, rdy_a}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
